// File: rtl/instruction_prefetch_if.sv
// Instruction prefetch bus bundle: the segment and redirect inputs, the memory
// read handshake and the decoder-side byte FIFO port. The prefetch unit uses the
// master modport. The memory/decoder environment uses the slave modport.
interface instruction_prefetch_if;
    logic [15:0] cs;
    logic [15:0] new_ip;
    logic        load_new_ip;
    logic        mem_access;
    logic        mem_ack;
    logic [18:0] mem_address;
    logic [15:0] mem_data;
    logic        fifo_rd_en;
    logic [7:0]  fifo_rd_data;
    logic        fifo_empty;

    modport master (
        input  cs, new_ip, load_new_ip, mem_ack, mem_data, fifo_rd_en,
        output mem_access, mem_address, fifo_rd_data, fifo_empty
    );

    modport slave (
        output cs, new_ip, load_new_ip, mem_ack, mem_data, fifo_rd_en,
        input  mem_access, mem_address, fifo_rd_data, fifo_empty
    );
endinterface

// File: rtl/instruction_prefetch.sv
// Instruction prefetch unit: fetches words at CS:IP over the memory bus and
// buffers the bytes in a small circular FIFO for the decoder. FIFO space is
// reserved when an access is issued, so a returning word always fits. A redirect
// (load_new_ip) flushes the FIFO. If a read is still outstanding, it is retired
// through ABORT and its data is dropped.
module instruction_prefetch #(
    parameter int DEPTH = 6
) (
    input  logic                   clk,
    input  logic                   reset_n,
    instruction_prefetch_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     fetch_ip_q, fetch_ip_d;
    logic            mem_access_q, mem_access_d;
    logic [18:0]     mem_address_q, mem_address_d;
    logic [7:0]      fifo_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            wr0_en_s, wr1_en_s;
    logic [PW-1:0]   wr0_idx_s, wr1_idx_s;
    logic [7:0]      wr0_data_s, wr1_data_s;
    logic [1:0]      push_cnt_s;
    logic            pop_s;
    logic            space_ok_s;
    logic [18:0]     word_addr_s;

    // Circular pointer advance; DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Word address of CS:IP. cs*16 has a zero LSB, so ip[0] never carries into bit 1.
    assign word_addr_s = {bus.cs, 3'b000} + {4'b0000, fetch_ip_q[15:1]};

    // An even fetch needs room for two bytes. An odd fetch needs room for one.
    assign space_ok_s = fetch_ip_q[0] ? (count_q <= CW'(DEPTH - 1))
                                      : (count_q <= CW'(DEPTH - 2));

    // Next-state logic for the fetch FSM, the FIFO pointers and the fetch IP.
    always_comb begin
        state_d       = state_q;
        fetch_ip_d    = fetch_ip_q;
        mem_access_d  = mem_access_q;
        mem_address_d = mem_address_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        wr0_en_s      = 1'b0;
        wr1_en_s      = 1'b0;
        wr0_idx_s     = wr_ptr_q;
        wr1_idx_s     = ptr_inc(wr_ptr_q);
        wr0_data_s    = bus.mem_data[7:0];
        wr1_data_s    = bus.mem_data[15:8];
        push_cnt_s    = 2'd0;
        pop_s         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!bus.load_new_ip && space_ok_s) begin
                    mem_access_d  = 1'b1;
                    mem_address_d = word_addr_s;
                    state_d       = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (bus.mem_ack) begin
                    mem_access_d = 1'b0;
                    state_d      = ST_IDLE;
                    if (!bus.load_new_ip) begin
                        if (fetch_ip_q[0]) begin
                            // Odd address: only the high byte belongs to the stream.
                            wr0_en_s   = 1'b1;
                            wr0_data_s = bus.mem_data[15:8];
                            push_cnt_s = 2'd1;
                            fetch_ip_d = fetch_ip_q + 16'd1;
                        end else begin
                            wr0_en_s   = 1'b1;
                            wr1_en_s   = 1'b1;
                            push_cnt_s = 2'd2;
                            fetch_ip_d = fetch_ip_q + 16'd2;
                        end
                    end else begin
                        push_cnt_s = 2'd0;
                    end
                end else if (bus.load_new_ip) begin
                    state_d = ST_ABORT;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_ABORT: begin
                if (bus.mem_ack) begin
                    mem_access_d = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_ABORT;
                end
            end
            default: begin
                mem_access_d = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase

        if (bus.load_new_ip) begin
            // A redirect overrides everything: flush and drop any pop or push.
            fetch_ip_d = bus.new_ip;
            rd_ptr_d   = {PW{1'b0}};
            wr_ptr_d   = {PW{1'b0}};
            count_d    = {CW{1'b0}};
            wr0_en_s   = 1'b0;
            wr1_en_s   = 1'b0;
        end else begin
            pop_s = bus.fifo_rd_en && (count_q != {CW{1'b0}});
            if (pop_s) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case (push_cnt_s)
                2'd1:    wr_ptr_d = ptr_inc(wr_ptr_q);
                2'd2:    wr_ptr_d = ptr_inc(ptr_inc(wr_ptr_q));
                default: wr_ptr_d = wr_ptr_q;
            endcase
            count_d = count_q + CW'(push_cnt_s) - CW'(pop_s);
        end
    end

    // State, bus request and FIFO bookkeeping registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            fetch_ip_q    <= 16'h0000;
            mem_access_q  <= 1'b0;
            mem_address_q <= 19'h00000;
            rd_ptr_q      <= {PW{1'b0}};
            wr_ptr_q      <= {PW{1'b0}};
            count_q       <= {CW{1'b0}};
        end else begin
            state_q       <= state_d;
            fetch_ip_q    <= fetch_ip_d;
            mem_access_q  <= mem_access_d;
            mem_address_q <= mem_address_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // FIFO byte storage, written with up to two bytes per returning word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= 8'h00;
            end
        end else begin
            if (wr0_en_s) begin
                fifo_q[wr0_idx_s] <= wr0_data_s;
            end
            if (wr1_en_s) begin
                fifo_q[wr1_idx_s] <= wr1_data_s;
            end
        end
    end

    assign bus.mem_access   = mem_access_q;
    assign bus.mem_address  = mem_address_q;
    assign bus.fifo_rd_data = fifo_q[rd_ptr_q];
    assign bus.fifo_empty   = (count_q == {CW{1'b0}});
endmodule
